// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed wait-state model and misalignment flagging.
// Optional byte-lane write enables are built when MEMRESP_BE_EN is defined.
module mem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_adr,
    input  logic [31:0] i_req_wdata,
`ifdef MEMRESP_BE_EN
    input  logic [3:0]  i_req_be,
`endif
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [AW+1:0]   r_adr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];
    logic [3:0]      w_be;
    logic [AW-1:0]   w_idx;
    logic            w_misal;
    logic            w_access;
    logic [31:0]     w_old;
    logic [31:0]     w_merged;
    logic            w_unused_adr;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

    // Only the index and alignment bits of the address matter; the rest alias.
    assign w_unused_adr = ^i_req_adr[31:AW+2];
    assign w_idx        = r_adr[AW+1:2];
    assign w_misal      = (r_adr[1:0] != 2'b00);
    assign w_access     = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_old        = r_mem[w_idx];
    assign w_merged     = merge_be(w_old, r_wdata, w_be);

`ifdef MEMRESP_BE_EN
    logic [3:0] r_be;

    // Byte-enable capture alongside the rest of the request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_be <= 4'b0000;
        end else if ((r_state == IDLE) && i_req_valid) begin
            r_be <= i_req_be;
        end
    end
    assign w_be = r_be;
`else
    assign w_be = 4'b1111;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_req_valid) w_next = BUSY;
                else             w_next = IDLE;
            end
            BUSY: begin
                if (r_cnt == 4'd0) w_next = RESP;
                else               w_next = BUSY;
            end
            RESP: begin
                if (i_resp_ready) w_next = IDLE;
                else              w_next = RESP;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture and wait-cycle countdown.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_cnt   <= 4'(WAIT);
                        r_we    <= i_req_we;
                        r_adr   <= i_req_adr[AW+1:0];
                        r_wdata <= i_req_wdata;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Response registers, loaded on the access edge and held through back-pressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            if (w_misal) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b1;
            end else if (r_we) begin
                r_rdata <= w_merged;
                r_err   <= 1'b0;
            end else begin
                r_rdata <= w_old;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage array; deliberately unreset. Reset forces IDLE, so a pending store never lands.
    always_ff @(posedge i_clk) begin
        if (w_access && r_we && !w_misal) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign o_req_ready  = (r_state == IDLE);
    assign o_resp_valid = (r_state == RESP);
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one WAIT=1 instance and one WAIT=0 instance.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, err1;
    logic [31:0] adr1, wdata1, rdata1;
    logic [3:0]  be1;
    logic        req_valid0, req_ready0, req_we0, resp_valid0, resp_ready0, err0;
    logic [31:0] adr0, wdata0, rdata0;
    logic [3:0]  be0;

    mem_responder #(.DEPTH(64), .WAIT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid1), .o_req_ready(req_ready1),
        .i_req_we(req_we1), .i_req_adr(adr1), .i_req_wdata(wdata1),
`ifdef MEMRESP_BE_EN
        .i_req_be(be1),
`endif
        .o_resp_valid(resp_valid1), .i_resp_ready(resp_ready1),
        .o_resp_rdata(rdata1), .o_resp_err(err1)
    );

    mem_responder #(.DEPTH(64), .WAIT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0),
        .i_req_we(req_we0), .i_req_adr(adr0), .i_req_wdata(wdata0),
`ifdef MEMRESP_BE_EN
        .i_req_be(be0),
`endif
        .o_resp_valid(resp_valid0), .i_resp_ready(resp_ready0),
        .o_resp_rdata(rdata0), .o_resp_err(err0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitors: compare on every response handshake; latency is first-valid cycle minus accept cycle.
    bit seen1 = 1'b0;
    int first1;
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid1 && !seen1) begin
            seen1  = 1'b1;
            first1 = cyc;
        end
        if (resp_valid1 && resp_ready1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_rdata", rdata1, e.rdata);
                check("dut1_err", 32'(err1), 32'(e.err));
                check("dut1_latency", 32'(first1 - e.acc), 32'd2);
            end
            seen1 = 1'b0;
        end
    end

    bit seen0 = 1'b0;
    int first0;
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid0 && !seen0) begin
            seen0  = 1'b1;
            first0 = cyc;
        end
        if (resp_valid0 && resp_ready0) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("dut0_rdata", rdata0, e.rdata);
                check("dut0_err", 32'(err0), 32'(e.err));
                check("dut0_latency", 32'(first0 - e.acc), 32'd1);
            end
            seen0 = 1'b0;
        end
    end

    task automatic req1(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        exp_t e;
        req_we1 = we; adr1 = adr; wdata1 = wd; be1 = be; req_valid1 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready1 && n < 20) begin @(negedge clk); n++; end
        if (!req_ready1) check("dut1_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        e.rdata = exp_rd; e.err = exp_err; e.acc = cyc;
        q1.push_back(e);
        // Scramble the request bus: the captured copy must be the one used.
        req_we1 = ~we; adr1 = 32'hFFFF_FFFC; wdata1 = 32'h0BAD_0BAD; be1 = ~be;
    endtask

    task automatic req0(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, output int acc);
        int   n;
        exp_t e;
        req_we0 = we; adr0 = adr; wdata0 = wd; be0 = 4'hF; req_valid0 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready0 && n < 20) begin @(negedge clk); n++; end
        if (!req_ready0) check("dut0_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        acc = cyc;
        e.rdata = exp_rd; e.err = 1'b0; e.acc = cyc;
        q0.push_back(e);
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        while (q1.size() != 0 && n < 50) begin @(posedge clk); n++; end
        if (q1.size() != 0) begin
            check("dut1_resp_timeout", 32'd0, 32'd1);
            q1.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int acc[8];
        rst_n = 1'b0;
        req_valid1 = 1'b0; req_we1 = 1'b0; adr1 = 32'd0; wdata1 = 32'd0; be1 = 4'hF; resp_ready1 = 1'b1;
        req_valid0 = 1'b0; req_we0 = 1'b0; adr0 = 32'd0; wdata0 = 32'd0; be0 = 4'hF; resp_ready0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready1), 32'd1);
        check("rst_resp_valid", 32'(resp_valid1), 32'd0);
        check("rst_rdata", rdata1, 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_dut0_req_ready", 32'(req_ready0), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store then load, plus an aliased load through high address bits.
        req1(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 1'b0); wait_idle1();
        req1(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);        wait_idle1();
        req1(1'b0, 32'hFFFF_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0); wait_idle1();

        // Back-pressure: response held for 5 cycles.
        resp_ready1 = 1'b0;
        req1(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        n = 0;
        @(negedge clk);
        while (!resp_valid1 && n < 20) begin @(negedge clk); n++; end
        if (!resp_valid1) check("bp_valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(resp_valid1), 32'd1);
            check("bp_rdata", rdata1, 32'hDEAD_BEEF);
            check("bp_req_ready", 32'(req_ready1), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready1 = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_req_ready", 32'(req_ready1), 32'd1);
        check("bp_idle_resp_valid", 32'(resp_valid1), 32'd0);
        wait_idle1();

        // Reset during BUSY drops a pending store.
        req1(1'b1, 32'h20, 32'h0000_5555, 4'hF, 32'h0000_5555, 1'b0); wait_idle1();
        req_we1 = 1'b1; adr1 = 32'h20; wdata1 = 32'hFFFF_0000; be1 = 4'hF; req_valid1 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready1), 32'd1);
        check("abort_resp_valid", 32'(resp_valid1), 32'd0);
        check("abort_rdata", rdata1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req1(1'b0, 32'h20, 32'h0, 4'hF, 32'h0000_5555, 1'b0); wait_idle1();

        // Alias and misalignment at DEPTH=64.
        req1(1'b1, 32'h100, 32'h0000_1234, 4'hF, 32'h0000_1234, 1'b0); wait_idle1();
        req1(1'b0, 32'h000, 32'h0, 4'hF, 32'h0000_1234, 1'b0);         wait_idle1();
        req1(1'b1, 32'h102, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);         wait_idle1();
        req1(1'b0, 32'h000, 32'h0, 4'hF, 32'h0000_1234, 1'b0);         wait_idle1();
        req1(1'b0, 32'h013, 32'h0, 4'hF, 32'h0, 1'b1);                 wait_idle1();

`ifdef MEMRESP_BE_EN
        req1(1'b1, 32'h40, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1'b0); wait_idle1();
        req1(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 1'b0); wait_idle1();
        req1(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 32'h11BB_33DD, 1'b0); wait_idle1();
        req1(1'b0, 32'h40, 32'h0, 4'b0000, 32'h11BB_33DD, 1'b0);         wait_idle1();
`else
        req1(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 32'hAABB_CCDD, 1'b0); wait_idle1();
        req1(1'b0, 32'h40, 32'h0, 4'b0000, 32'hAABB_CCDD, 1'b0);         wait_idle1();
`endif

        // WAIT=0 instance: four stores then four back-to-back loads.
        for (int i = 0; i < 4; i++) begin
            req0(1'b1, 32'(i * 4), 32'hA0A0_0000 + 32'(i), 32'hA0A0_0000 + 32'(i), acc[i]);
        end
        for (int i = 0; i < 4; i++) begin
            req0(1'b0, 32'(i * 4), 32'h0, 32'hA0A0_0000 + 32'(i), acc[4 + i]);
        end
        for (int i = 5; i < 8; i++) begin
            check("dut0_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
        end
        n = 0;
        while (q0.size() != 0 && n < 50) begin @(posedge clk); n++; end
        if (q0.size() != 0) check("dut0_resp_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder that services load, store and fetch requests from the multicycle controller over a valid/ready request channel and a valid/ready response channel. It sits on the memory side of the multicycle datapath and replaces the ideal zero-latency memory with a configurable wait-state model. Each transaction is accepted, held for a programmed number of wait cycles, then completed with a response that carries read data or a write acknowledge. The block also flags misaligned accesses.

## Interface
- DEPTH, 64: memory size in 32-bit words; power of two, 4..4096.
- WAIT, 1: wait cycles inserted before each access completes; 0..15.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load or fetch.
- req_adr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; lane i = bits [8i+7:8i]. Present only with MEMRESP_BE_EN.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  read data, or the post-write word for stores.
- resp_err  out  1  misaligned access.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset enters IDLE.
- IDLE:
  - req_ready=1 and resp_valid=0.
  - When req_valid=1 at a rising edge, capture adr, we, wdata and be into holding registers, load cnt=WAIT, and go to BUSY.
- BUSY:
  - req_ready=0 and resp_valid=0.
  - When cnt≠0, decrement cnt.
  - When cnt=0, perform the access on this edge, register resp_rdata and resp_err, and go to RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_err stay stable until the handshake.
  - When resp_ready=1 at an edge, go to IDLE.
  - No request is accepted in RESP. req_ready=0.
- Index: idx = adr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH×4.
- Misaligned (adr[1:0]≠0):
  - resp_err=1 and resp_rdata=0.
  - Memory is not modified.
- Load: resp_rdata = mem[idx] and resp_err=0.
- Store:
  - mem[idx] is updated, then resp_rdata = updated word and resp_err=0.
  - Read and write of the same word within one access return the new value.
- Request-channel inputs are ignored outside IDLE. The captured copy is authoritative, so requester changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0. Memory contents are not reset.
- Latency: acceptance at edge T puts resp_valid=1 in the cycle after edge T+WAIT+1.
  - WAIT=0 gives resp_valid=1 two cycles after the accept cycle.
  - The memory write occurs at edge T+WAIT+1.
- Back-pressure: resp_valid may be held for any number of cycles, and outputs remain unchanged.
- Minimum turnaround from one accept to the next is WAIT+3 cycles, assuming resp_ready is held high.
- req_ready is a decode of state=IDLE. It has no combinational path from req_valid or resp_ready.
- Reset assertion mid-transaction:
  - The outstanding transaction is dropped and state returns to IDLE immediately.
  - A store not yet written at its access edge never reaches memory.

## Configuration
- MEMRESP_BE_EN defined:
  - The req_be port exists and is captured with the request.
  - A store writes only enabled byte lanes. Disabled lanes retain their old value.
  - be=4'b0000 performs no write but still responds, with resp_rdata = unchanged word.
- MEMRESP_BE_EN undefined:
  - No req_be port.
  - All stores write the full 32-bit word.

## Test plan
- Reset: drive reset=0 mid-BUSY with a store pending, release reset, then load the same address → the store did not land, req_ready=1 and resp_valid=0 right after reset.
- Store then load, WAIT=1: store 0xDEADBEEF to 0x10, then load 0x10 → both responses appear 3 cycles after the accept cycle, and the load returns resp_rdata=0xDEADBEEF with resp_err=0.
- Back-pressure: load with resp_ready=0 for 5 cycles → resp_valid and resp_rdata hold constant, req_ready=0 throughout, and the handshake returns the FSM to IDLE on the next edge.
- Misaligned and alias, DEPTH=64:
  - Store to 0x102 → resp_err=1, resp_rdata=0, and mem unchanged.
  - Store 0x1234 to 0x100, then load 0x000 → 0x1234 (alias).
- WAIT=0 throughput: 4 back-to-back loads with resp_ready=1 → an accept every 3 cycles, with correct data for each.
- MEMRESP_BE_EN: word = 0x11223344; store 0xAABBCCDD with be=4'b0101 → resp_rdata=0x11BB33DD. Then be=0 → resp_rdata unchanged.
